// File: rtl/rf_write_scheduler_pkg.sv
// Shared definitions for the register-file write path: geometry of the
// 16x8 dual-write-port register file and the bank-select helper.
// No ports; imported by the interface, the bank FIFO and the top level.
package rf_write_scheduler_pkg;

   localparam int unsigned RF_DW      = 8;
   localparam int unsigned RF_ENTRIES = 16;
   localparam int unsigned RF_AW      = $clog2(RF_ENTRIES);
   localparam int unsigned RF_BANK_AW = RF_AW - 1;

   typedef enum logic {
      BANK_LO = 1'b0,
      BANK_HI = 1'b1
   } bank_e;

   // The top address bit picks the bank: 0-7 low, 8-15 high.
   function automatic bank_e bank_of(input logic addr_msb);
      return addr_msb ? BANK_HI : BANK_LO;
   endfunction

endpackage

// File: rtl/rf_write_scheduler_if.sv
// Write-request stream into the scheduler (valid/ready handshake).
// Signals: in_valid, in_ready, in_addr (entry 0-15), in_data (DW bits).
// master = upstream producer, slave = rf_write_scheduler.
interface rf_write_scheduler_if
   import rf_write_scheduler_pkg::*;
#(
   parameter int unsigned DW = RF_DW
);
   logic             in_valid;
   logic             in_ready;
   logic [RF_AW-1:0] in_addr;
   logic [DW-1:0]    in_data;

   modport master (
      output in_valid,
      output in_addr,
      output in_data,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_addr,
      input  in_data,
      output in_ready
   );
endinterface

// File: rtl/rf_write_scheduler_sync_fifo.sv
// Single-clock FIFO used as one bank queue of the write scheduler.
// Ports: clk, rst (sync, active-high), push/wdata, pop/rdata (head, valid
// when !empty), full, empty, count (0..DEPTH).
// Push while full and pop while empty are ignored.
module rf_write_scheduler_sync_fifo #(
   parameter int unsigned W     = 11,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [W-1:0]               wdata,
   input  logic                       pop,
   output logic [W-1:0]               rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign rdata   = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Storage carries no reset: only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/rf_write_scheduler.sv
// Write scheduler in front of the 16x8 dual-write-port register file.
// Steers each accepted request into a low (0-7) or high (8-15) bank FIFO
// and drains both banks in parallel, one write per bank per cycle.
// Ports: clk, rst (sync, active-high), req (request stream, slave side),
// hold (stall dispatch), wr_en_1/wr_addr_1/data_in_1 (low bank port),
// wr_en_2/wr_addr_2/data_in_2 (high bank port), lo_count/hi_count
// (FIFO occupancy), busy (anything queued or being written).
module rf_write_scheduler
   import rf_write_scheduler_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DW    = RF_DW
) (
   input  logic                     clk,
   input  logic                     rst,
   rf_write_scheduler_if.slave      req,
   input  logic                     hold,
   output logic                     wr_en_1,
   output logic [RF_BANK_AW-1:0]    wr_addr_1,
   output logic [DW-1:0]            data_in_1,
   output logic                     wr_en_2,
   output logic [RF_BANK_AW-1:0]    wr_addr_2,
   output logic [DW-1:0]            data_in_2,
   output logic [$clog2(DEPTH):0]   lo_count,
   output logic [$clog2(DEPTH):0]   hi_count,
   output logic                     busy
);

   localparam int unsigned EW = RF_BANK_AW + DW;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("rf_write_scheduler: DEPTH must be a power of two >= 2");
   end

   logic          accept;
   logic          push_lo;
   logic          push_hi;
   logic          pop_lo;
   logic          pop_hi;
   logic          lo_full;
   logic          hi_full;
   logic          lo_empty;
   logic          hi_empty;
   logic [EW-1:0] entry;
   logic [EW-1:0] lo_head;
   logic [EW-1:0] hi_head;

   // Ready is withheld if either bank is full so it never depends on in_addr.
   assign req.in_ready = !rst && !lo_full && !hi_full;
   assign accept       = req.in_valid && req.in_ready;
   assign entry        = {req.in_addr[RF_BANK_AW-1:0], req.in_data};
   assign push_lo      = accept && (bank_of(req.in_addr[RF_AW-1]) == BANK_LO);
   assign push_hi      = accept && (bank_of(req.in_addr[RF_AW-1]) == BANK_HI);
   assign pop_lo       = !hold && !lo_empty;
   assign pop_hi       = !hold && !hi_empty;

   rf_write_scheduler_sync_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_lo_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_lo),
      .wdata (entry),
      .pop   (pop_lo),
      .rdata (lo_head),
      .full  (lo_full),
      .empty (lo_empty),
      .count (lo_count)
   );

   rf_write_scheduler_sync_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_hi_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_hi),
      .wdata (entry),
      .pop   (pop_hi),
      .rdata (hi_head),
      .full  (hi_full),
      .empty (hi_empty),
      .count (hi_count)
   );

   // Dispatch registers: a popped head is presented for exactly one cycle;
   // address/data hold their last value while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en_1   <= 1'b0;
         wr_addr_1 <= '0;
         data_in_1 <= '0;
         wr_en_2   <= 1'b0;
         wr_addr_2 <= '0;
         data_in_2 <= '0;
      end else begin
         wr_en_1 <= pop_lo;
         wr_en_2 <= pop_hi;
         if (pop_lo) begin
            wr_addr_1 <= lo_head[EW-1:DW];
            data_in_1 <= lo_head[DW-1:0];
         end
         if (pop_hi) begin
            wr_addr_2 <= hi_head[EW-1:DW];
            data_in_2 <= hi_head[DW-1:0];
         end
      end
   end

   assign busy = (lo_count != '0) || (hi_count != '0) || wr_en_1 || wr_en_2;

endmodule
